// File: rtl/inv_cipher_core_if.sv
// Block-in / block-out handshake and round-key lookup bundle for the AES inverse cipher core.
// The slave side is the core; the master side feeds ciphertext, serves round keys and drains plaintext.
interface inv_cipher_core_if;
   logic             in_valid;
   logic             in_ready;
   logic [15:0][7:0] ciphertext;
   logic [3:0]       key_idx;
   logic [15:0][7:0] round_key;
   logic             out_valid;
   logic             out_ready;
   logic [15:0][7:0] plaintext;
   logic             busy;

   modport slave (
      input  in_valid, ciphertext, round_key, out_ready,
      output in_ready, key_idx, out_valid, plaintext, busy
   );

   modport master (
      output in_valid, ciphertext, round_key, out_ready,
      input  in_ready, key_idx, out_valid, plaintext, busy
   );
endinterface

// File: rtl/inv_cipher_core.sv
// Iterative AES inverse cipher: one round per clock, round keys fetched from an external store via key_idx.
// Packed byte 15 holds FIPS-197 byte 0; FIPS byte i sits at row i%4, column i/4.
module inv_cipher_core #(
   parameter int NR = 10
) (
   input logic          clk,
   input logic          reset,
   inv_cipher_core_if.slave bus
);
   typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_e;

   localparam logic [3:0] NR4 = 4'(NR);

   state_e           state_q;
   logic [3:0]       rnd_q;
   logic [3:0]       key_idx_q;
   logic [15:0][7:0] st_q;
   logic [15:0][7:0] pt_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;

   logic [15:0][7:0] sub_d;
   logic [15:0][7:0] final_d;
   logic [15:0][7:0] round_d;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         p  = p ^ (b[i] ? aa : 8'h00);
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0 naturally).
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] r;
      sq = a;
      r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      logic [7:0] t;
      t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
      return ginv(t);
   endfunction

   function automatic logic [15:0][7:0] inv_shift_sub(input logic [15:0][7:0] s);
      logic [15:0][7:0] o;
      logic [3:0]       di;
      logic [3:0]       si;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            di    = 4'(15 - (4 * c + r));
            si    = 4'(15 - (4 * ((c + 4 - r) % 4) + r));
            o[di] = inv_sbox(s[si]);
         end
      end
      return o;
   endfunction

   function automatic logic [15:0][7:0] inv_mix(input logic [15:0][7:0] s);
      logic [15:0][7:0] o;
      logic [7:0]       a0, a1, a2, a3;
      logic [3:0]       b;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         b  = 4'(15 - 4 * c);
         a0 = s[b];
         a1 = s[b - 4'd1];
         a2 = s[b - 4'd2];
         a3 = s[b - 4'd3];
         o[b]        = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[b - 4'd1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[b - 4'd2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[b - 4'd3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

   // Round datapath: shared InvShiftRows/InvSubBytes/AddRoundKey, InvMixColumns only on full rounds.
   always_comb begin
      sub_d   = inv_shift_sub(st_q);
      final_d = sub_d ^ bus.round_key;
      round_d = inv_mix(final_d);
   end

   // Control FSM and all registered state/outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         rnd_q       <= 4'd0;
         key_idx_q   <= 4'd0;
         st_q        <= '0;
         pt_q        <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  st_q       <= bus.ciphertext;
                  rnd_q      <= NR4;
                  key_idx_q  <= NR4;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= INIT;
               end
            end
            INIT: begin
               st_q      <= st_q ^ bus.round_key;
               rnd_q     <= NR4 - 4'd1;
               key_idx_q <= NR4 - 4'd1;
               state_q   <= ROUND;
            end
            ROUND: begin
               st_q <= round_d;
               if (rnd_q == 4'd1) begin
                  key_idx_q <= 4'd0;
                  state_q   <= FINAL;
               end else begin
                  rnd_q     <= rnd_q - 4'd1;
                  key_idx_q <= rnd_q - 4'd1;
               end
            end
            FINAL: begin
               pt_q        <= final_d;
               out_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               key_idx_q   <= 4'd0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   // in_ready is masked while reset is held so nothing appears acceptable during reset.
   assign bus.in_ready  = in_ready_q & ~reset;
   assign bus.key_idx   = key_idx_q;
   assign bus.out_valid = out_valid_q;
   assign bus.plaintext = pt_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_inv_cipher_core.sv
// Bench for inv_cipher_core: FIPS-197 vectors plus random blocks produced by a forward AES-128 model.
module tb_inv_cipher_core;
   logic clk;
   logic reset;
   int unsigned cyc;
   int unsigned checks;
   int unsigned errors;
   int unsigned acc_cyc;

   logic [7:0]   sbox_t [256];
   logic [127:0] rk_store [0:10];

   inv_cipher_core_if bus ();

   inv_cipher_core #(.NR(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Key-schedule store: combinational lookup by the core's key_idx.
   assign bus.round_key = (bus.key_idx <= 4'd10) ? rk_store[bus.key_idx] : '0;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] bi(input int i);
      return 4'(15 - i);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] acc;
      acc = 16'h0000;
      for (int i = 0; i < 8; i++) if (b[i]) acc = acc ^ (16'({8'h00, a}) << i);
      for (int i = 15; i >= 8; i--) if (acc[i]) acc = acc ^ (16'h011b << (i - 8));
      return acc[7:0];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] x;
      for (int v = 0; v < 256; v++) begin
         x   = 8'(v);
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gm(x, 8'(y)) == 8'h01) inv = 8'(y);
         sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   task automatic expand(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[6'(i)] = key[127 - 32 * i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[6'(i - 1)];
         if (i % 4 == 0) begin
            t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rcon, 24'h000000};
            rcon = gm(rcon, 8'h02);
         end
         w[6'(i)] = w[6'(i - 4)] ^ t;
      end
      for (int r = 0; r < 11; r++)
         rk_store[4'(r)] = {w[6'(4 * r)], w[6'(4 * r + 1)], w[6'(4 * r + 2)], w[6'(4 * r + 3)]};
   endtask

   function automatic logic [127:0] encrypt(input logic [127:0] pt);
      logic [15:0][7:0] s, t, k;
      logic [7:0]       a0, a1, a2, a3;
      s = pt ^ rk_store[0];
      for (int r = 1; r <= 10; r++) begin
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) t[bi(4 * c + w)] = sbox_t[s[bi(4 * ((c + w) % 4) + w)]];
         s = t;
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = t[bi(4 * c)]; a1 = t[bi(4 * c + 1)]; a2 = t[bi(4 * c + 2)]; a3 = t[bi(4 * c + 3)];
               s[bi(4 * c)]     = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
               s[bi(4 * c + 1)] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
               s[bi(4 * c + 2)] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
               s[bi(4 * c + 3)] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
            end
         end
         k = rk_store[4'(r)];
         s = s ^ k;
      end
      return s;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // One block: accept, trace key_idx/out_valid for 12 cycles, check result, optional backpressure.
   task automatic run_block(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] exp_pt,
                            input int hold);
      int n;
      expand(key);
      bus.ciphertext = ct;
      bus.in_valid   = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 30) begin
         tick();
         n++;
      end
      chk("accept_wait_in_ready", 128'(bus.in_ready), 128'(1'b1));
      if (!bus.in_ready) return;
      tick();
      acc_cyc        = cyc;
      bus.in_valid   = 1'b0;
      bus.ciphertext = rnd128();
      for (int k = 0; k <= 11; k++) begin
         chk("key_idx_trace", 128'(bus.key_idx), 128'((k <= 9) ? (10 - k) : 0));
         chk("out_valid_latency", 128'(bus.out_valid), 128'(k == 11));
         chk("busy_in_flight", 128'(bus.busy), 128'(1'b1));
         if (k < 11) tick();
      end
      chk("plaintext", bus.plaintext, exp_pt);
      chk("in_ready_done", 128'(bus.in_ready), 128'(1'b0));
      if (hold > 0) begin
         bus.out_ready  = 1'b0;
         bus.in_valid   = 1'b1;
         bus.ciphertext = rnd128();
         for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_plaintext", bus.plaintext, exp_pt);
            chk("hold_out_valid", 128'(bus.out_valid), 128'(1'b1));
            chk("hold_in_ready", 128'(bus.in_ready), 128'(1'b0));
            chk("hold_key_idx", 128'(bus.key_idx), 128'(0));
         end
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b1;
         tick();
         chk("release_out_valid", 128'(bus.out_valid), 128'(1'b0));
         chk("release_in_ready", 128'(bus.in_ready), 128'(1'b1));
         chk("release_busy", 128'(bus.busy), 128'(1'b0));
         chk("idle_key_idx", 128'(bus.key_idx), 128'(0));
      end
   endtask

   localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;

   initial begin
      int unsigned a1;
      logic        seen;
      logic [127:0] key, pt, ct;
      cyc = 0; checks = 0; errors = 0; acc_cyc = 0;
      reset = 1'b1;
      bus.in_valid   = 1'b0;
      bus.out_ready  = 1'b1;
      bus.ciphertext = '0;
      build_sbox();
      expand(K_C1);
      tick();
      tick();
      chk("reset_in_ready_low", 128'(bus.in_ready), 128'(1'b0));
      reset = 1'b0;
      #1;
      chk("reset_in_ready_high", 128'(bus.in_ready), 128'(1'b1));
      chk("reset_out_valid", 128'(bus.out_valid), 128'(1'b0));
      chk("reset_busy", 128'(bus.busy), 128'(1'b0));
      chk("reset_plaintext", bus.plaintext, 128'(0));
      chk("reset_key_idx", 128'(bus.key_idx), 128'(0));

      run_block(K_C1, C_C1, P_C1, 20);

      // Reset five cycles into a block.
      bus.ciphertext = C_C1;
      bus.in_valid   = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("midreset_in_ready", 128'(bus.in_ready), 128'(1'b1));
      chk("midreset_out_valid", 128'(bus.out_valid), 128'(1'b0));
      chk("midreset_plaintext", bus.plaintext, 128'(0));
      chk("midreset_busy", 128'(bus.busy), 128'(1'b0));
      seen = 1'b0;
      for (int k = 0; k < 15; k++) begin
         tick();
         seen = seen | bus.out_valid;
      end
      chk("midreset_no_out_valid", 128'(seen), 128'(1'b0));
      run_block(K_C1, C_C1, P_C1, 0);

      run_block(K_C1, C_C1, P_C1, 0);
      a1 = acc_cyc;
      run_block(K_B, C_B, P_B, 0);
      chk("b2b_accept_spacing", 128'(acc_cyc - a1), 128'(13));

      for (int r = 0; r < 4; r++) begin
         key = rnd128();
         pt  = rnd128();
         expand(key);
         ct  = encrypt(pt);
         run_block(key, ct, pt, int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
